// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared types and constants for the alarm-clock mode controller.
//   state_t       - FSM state encoding (also exported on state_o for debug)
//   mode_req_t    - decoded set-mode request from the time/alarm set buttons
//   TW            - width of every time value (seconds, minutes, hours)
//   NS_DEF/NH_DEF - default moduli of the sec/min and hour counters
// ----------------------------------------------------------------------------
package clock_pkg;

  localparam int TW     = 7;
  localparam int NS_DEF = 60;
  localparam int NH_DEF = 24;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_TIME  = 3'd1,
    ST_SET_ALARM = 3'd2,
    ST_RINGING   = 3'd3,
    ST_SNOOZE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_TIME  = 2'd1,
    REQ_ALARM = 2'd2
  } mode_req_t;

  // Pressing both set buttons at once is ambiguous, so it requests nothing.
  function automatic mode_req_t decode_mode_req(input logic timeset,
                                                input logic alarmset);
    if (timeset && !alarmset) return REQ_TIME;
    if (alarmset && !timeset) return REQ_ALARM;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/run_enables.sv
// ----------------------------------------------------------------------------
// run_enables
// Combinational enable decode for the seconds/minutes/hours counters.
// In normal mode the enables form a ripple carry from the 1/sec tick; in
// manual mode the seconds are frozen and the advance buttons step minutes
// and hours independently, one step per tick.
//   i_tick      1/sec strobe
//   i_manual    1 = manual (button) stepping, 0 = normal time keeping
//   i_minadv    minute advance button
//   i_hrsadv    hour advance button
//   i_tsec      current seconds value
//   i_tmin      current minutes value
//   o_sec_en    seconds counter enable
//   o_min_en    minutes counter enable
//   o_hrs_en    hours counter enable
// ----------------------------------------------------------------------------
module run_enables
  import clock_pkg::*;
#(
  parameter int NS = NS_DEF
) (
  input  logic          i_tick,
  input  logic          i_manual,
  input  logic          i_minadv,
  input  logic          i_hrsadv,
  input  logic [TW-1:0] i_tsec,
  input  logic [TW-1:0] i_tmin,
  output logic          o_sec_en,
  output logic          o_min_en,
  output logic          o_hrs_en
);

  localparam logic [TW-1:0] LAST = TW'(NS - 1);

  logic w_sec_last;
  logic w_min_last;

  assign w_sec_last = (i_tsec == LAST);
  assign w_min_last = (i_tmin == LAST);

  // Manual stepping deliberately has no minute-to-hour carry.
  assign o_sec_en = i_tick && !i_manual;
  assign o_min_en = i_tick && (i_manual ? i_minadv : w_sec_last);
  assign o_hrs_en = i_tick && (i_manual ? i_hrsadv : (w_sec_last && w_min_last));

endmodule

// File: rtl/clock_mode_ctrl.sv
// ----------------------------------------------------------------------------
// clock_mode_ctrl
// Central sequencer of the alarm-clock datapath. A registered FSM decodes the
// manual buttons and the 1/sec tick into single-cycle counter enables, picks
// the display source, and runs alarm ringing with auto-stop and snooze.
//   clk                      system clock
//   rst                      synchronous reset, active-low
//   tick                     one-cycle strobe, once per second
//   timeset, alarmset        set-mode buttons (synchronised levels)
//   minadv, hrsadv           advance buttons
//   alarmon                  alarm armed switch
//   snooze                   snooze button
//   tsec, tmin, thrs         current time counter values
//   amin, ahrs               alarm register values
//   sec_en, tmin_en, thrs_en time counter enables (only ever with tick)
//   amin_en, ahrs_en         alarm register enables
//   sec_clr                  seconds clear, first cycle of time setting
//   disp_alarm               1 = display shows the alarm value
//   buzz                     alarm sound, high only while ringing
//   state_o                  current FSM state (debug)
// ----------------------------------------------------------------------------
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int NS         = NS_DEF,
  parameter int NH         = NH_DEF,
  parameter int RING_SEC   = 120,
  parameter int SNOOZE_SEC = 540
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          timeset,
  input  logic          alarmset,
  input  logic          minadv,
  input  logic          hrsadv,
  input  logic          alarmon,
  input  logic          snooze,
  input  logic [TW-1:0] tsec,
  input  logic [TW-1:0] tmin,
  input  logic [TW-1:0] thrs,
  input  logic [TW-1:0] amin,
  input  logic [TW-1:0] ahrs,
  output logic          sec_en,
  output logic          tmin_en,
  output logic          thrs_en,
  output logic          amin_en,
  output logic          ahrs_en,
  output logic          sec_clr,
  output logic          disp_alarm,
  output logic          buzz,
  output logic [2:0]    state_o
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);

  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNOOZE_SEC);
  localparam logic [SW-1:0] SNZ_LAST   = SW'(1);
  localparam logic [TW-1:0] HRS_LAST   = TW'(NH - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [RW-1:0]   r_ring_cnt;
  logic [SW-1:0]   r_snz_cnt;
  logic            r_snooze_q;
  logic            r_was_set_time;

  state_t          w_state_nxt;
  logic [RW-1:0]   w_ring_nxt;
  logic [SW-1:0]   w_snz_nxt;

  mode_req_t       w_req;
  logic            w_trig;
  logic            w_snooze_rise;
  logic            w_ring_done;
  logic            w_snz_done;

  assign w_req         = decode_mode_req(timeset, alarmset);
  assign w_snooze_rise = snooze && !r_snooze_q;
  assign w_ring_done   = tick && (r_ring_cnt == RING_LAST);
  assign w_snz_done    = tick && (r_snz_cnt == SNZ_LAST);

  // An alarm hour outside the hour counter range can never match the time,
  // so it is screened out rather than compared.
  assign w_trig = tick && alarmon && (tsec == '0) &&
                  (tmin == amin) && (thrs == ahrs) && (ahrs <= HRS_LAST);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring_cnt;
    w_snz_nxt   = r_snz_cnt;

    if (w_req == REQ_TIME) begin
      w_state_nxt = ST_SET_TIME;
      w_ring_nxt  = '0;
      w_snz_nxt   = '0;
    end else if (w_req == REQ_ALARM) begin
      w_state_nxt = ST_SET_ALARM;
      w_ring_nxt  = '0;
      w_snz_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_SET_TIME,
        ST_SET_ALARM: w_state_nxt = ST_RUN;

        ST_RUN: begin
          if (w_trig) begin
            w_state_nxt = ST_RINGING;
            w_ring_nxt  = '0;
          end
        end

        ST_RINGING: begin
          if (!alarmon) begin
            w_state_nxt = ST_RUN;
          end else if (w_snooze_rise) begin
            w_state_nxt = ST_SNOOZE;
            w_snz_nxt   = SNZ_LOAD;
          end else if (w_ring_done) begin
            w_state_nxt = ST_RUN;
          end else if (tick && (r_ring_cnt != RING_LAST)) begin
            w_ring_nxt = r_ring_cnt + RW'(1);
          end
        end

        ST_SNOOZE: begin
          if (!alarmon) begin
            w_state_nxt = ST_RUN;
          end else if (w_snz_done) begin
            w_state_nxt = ST_RINGING;
            w_ring_nxt  = '0;
          end else if (tick && (r_snz_cnt != '0)) begin
            w_snz_nxt = r_snz_cnt - SW'(1);
          end
        end

        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (!rst) begin
      // NOTE: every register is reset; there is no storage array here whose
      // reset would need to be left to the datapath.
      r_state        <= ST_RUN;
      r_ring_cnt     <= '0;
      r_snz_cnt      <= '0;
      r_snooze_q     <= 1'b0;
      r_was_set_time <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ring_cnt     <= w_ring_nxt;
      r_snz_cnt      <= w_snz_nxt;
      r_snooze_q     <= snooze;
      r_was_set_time <= (r_state == ST_SET_TIME);
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  logic w_in_set_time;
  logic w_in_set_alarm;

  assign w_in_set_time  = (r_state == ST_SET_TIME);
  assign w_in_set_alarm = (r_state == ST_SET_ALARM);

  // One decoder serves both paths: in SET_TIME the buttons step the time
  // counters, everywhere else the tick ripples through them.
  run_enables #(
    .NS (NS)
  ) u_run_enables (
    .i_tick   (tick),
    .i_manual (w_in_set_time),
    .i_minadv (minadv),
    .i_hrsadv (hrsadv),
    .i_tsec   (tsec),
    .i_tmin   (tmin),
    .o_sec_en (sec_en),
    .o_min_en (tmin_en),
    .o_hrs_en (thrs_en)
  );

  always_comb begin
    amin_en    = 1'b0;
    ahrs_en    = 1'b0;
    sec_clr    = 1'b0;
    disp_alarm = 1'b0;
    buzz       = 1'b0;

    if (w_in_set_alarm) begin
      amin_en    = tick && minadv;
      ahrs_en    = tick && hrsadv;
      disp_alarm = 1'b1;
    end

    // Seconds restart from zero on the first cycle of time setting only.
    if (w_in_set_time && !r_was_set_time) begin
      sec_clr = 1'b1;
    end

    if (r_state == ST_RINGING) begin
      buzz = 1'b1;
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clock_mode_ctrl
// Directed bench for clock_mode_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. The time inputs come from a
// small wall-clock model kept in the bench.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       timeset = 1'b0, alarmset = 1'b0, minadv = 1'b0, hrsadv = 1'b0;
  logic       alarmon = 1'b0, snooze = 1'b0;
  logic [6:0] tsec = '0, tmin = '0, thrs = '0, amin = '0, ahrs = '0;
  logic       sec_en, tmin_en, thrs_en, amin_en, ahrs_en;
  logic       sec_clr, disp_alarm, buzz;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  int m_s = 0, m_m = 0, m_h = 0;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .NS         (60),
    .NH         (24),
    .RING_SEC   (120),
    .SNOOZE_SEC (540)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .timeset    (timeset),
    .alarmset   (alarmset),
    .minadv     (minadv),
    .hrsadv     (hrsadv),
    .alarmon    (alarmon),
    .snooze     (snooze),
    .tsec       (tsec),
    .tmin       (tmin),
    .thrs       (thrs),
    .amin       (amin),
    .ahrs       (ahrs),
    .sec_en     (sec_en),
    .tmin_en    (tmin_en),
    .thrs_en    (thrs_en),
    .amin_en    (amin_en),
    .ahrs_en    (ahrs_en),
    .sec_clr    (sec_clr),
    .disp_alarm (disp_alarm),
    .buzz       (buzz),
    .state_o    (state_o)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_time();
    tsec = 7'(m_s);
    tmin = 7'(m_m);
    thrs = 7'(m_h);
  endtask

  task automatic adv_time();
    m_s++;
    if (m_s == 60) begin
      m_s = 0;
      m_m++;
      if (m_m == 60) begin
        m_m = 0;
        m_h = (m_h + 1) % 24;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst    = 1'b0;
    snooze = 1'b1;
    tick   = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if (state_o !== 3'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", state_o);
    end
    total++;
    if ({sec_en, tmin_en, thrs_en, amin_en, ahrs_en, sec_clr, disp_alarm, buzz} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {sec_en, tmin_en, thrs_en, amin_en, ahrs_en, sec_clr, disp_alarm, buzz});
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (state_o !== 3'd0) begin
      bad++; $display("FAIL reset_release_state got=%0d exp=0", state_o);
    end
    next_cycle();
    snooze = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_run_timing();
    int n_sec = 0, n_min = 0, n_hrs = 0, n_buzz = 0, n_other = 0;
    int hrs_at_ok = 0;
    alarmon = 1'b0; amin = '0; ahrs = '0;
    m_s = 0; m_m = 0; m_h = 0;
    for (int i = 0; i < 3600; i++) begin
      tick = 1'b1;
      drive_time();
      @(negedge clk);
      if (sec_en)  n_sec++;
      if (tmin_en) n_min++;
      if (thrs_en) begin
        n_hrs++;
        if (m_s == 59 && m_m == 59) hrs_at_ok = 1;
      end
      if (buzz || state_o != 3'd0) n_buzz++;
      if (amin_en || ahrs_en || sec_clr || disp_alarm) n_other++;
      next_cycle();
      adv_time();
    end
    tick = 1'b0;
    total++;
    if (n_sec !== 3600) begin bad++; $display("FAIL run_sec_count got=%0d exp=3600", n_sec); end
    total++;
    if (n_min !== 60) begin bad++; $display("FAIL run_min_count got=%0d exp=60", n_min); end
    total++;
    if (n_hrs !== 1) begin bad++; $display("FAIL run_hrs_count got=%0d exp=1", n_hrs); end
    total++;
    if (hrs_at_ok !== 1) begin bad++; $display("FAIL run_hrs_at_5959 got=%0d exp=1", hrs_at_ok); end
    total++;
    if (n_buzz !== 0) begin bad++; $display("FAIL run_quiet got=%0d exp=0", n_buzz); end
    total++;
    if (n_other !== 0) begin bad++; $display("FAIL run_other_outs got=%0d exp=0", n_other); end

    // Carry position but no tick: nothing may be enabled.
    tsec = 7'd59; tmin = 7'd59;
    @(negedge clk);
    total++;
    if ({sec_en, tmin_en, thrs_en} !== 3'b000) begin
      bad++; $display("FAIL run_no_tick got=%b exp=000", {sec_en, tmin_en, thrs_en});
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_set_time();
    int n_sec = 0, n_min = 0, n_hrs = 0, n_clr = 0;
    tick = 1'b0; tsec = 7'd59; tmin = 7'd59; thrs = 7'd5;
    timeset = 1'b1; minadv = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (state_o !== 3'd1) begin bad++; $display("FAIL set_time_state got=%0d exp=1", state_o); end
    total++;
    if (sec_clr !== 1'b1) begin bad++; $display("FAIL set_time_clr_entry got=%b exp=1", sec_clr); end
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      @(negedge clk);
      if (sec_en)  n_sec++;
      if (tmin_en) n_min++;
      if (thrs_en) n_hrs++;
      if (sec_clr) n_clr++;
      next_cycle();
    end
    tick = 1'b0;
    @(negedge clk);
    total++;
    if ({sec_en, tmin_en, thrs_en, sec_clr, disp_alarm} !== 5'b00000) begin
      bad++;
      $display("FAIL set_time_idle got=%b exp=00000", {sec_en, tmin_en, thrs_en, sec_clr, disp_alarm});
    end
    total++;
    if (n_min !== 5) begin bad++; $display("FAIL set_time_min_count got=%0d exp=5", n_min); end
    total++;
    if (n_sec !== 0) begin bad++; $display("FAIL set_time_sec_frozen got=%0d exp=0", n_sec); end
    total++;
    if (n_hrs !== 0) begin bad++; $display("FAIL set_time_no_carry got=%0d exp=0", n_hrs); end
    total++;
    if (n_clr !== 0) begin bad++; $display("FAIL set_time_clr_once got=%0d exp=0", n_clr); end
    next_cycle();
    timeset = 1'b0; minadv = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if (state_o !== 3'd0) begin bad++; $display("FAIL set_time_release got=%0d exp=0", state_o); end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_set_alarm();
    int n_ahrs = 0, n_amin = 0, n_sec = 0, n_disp = 0, n_state = 0;
    // Time equals the alarm with tsec=0 on every tick: no trigger while setting.
    alarmset = 1'b1; hrsadv = 1'b1; alarmon = 1'b1;
    amin = 7'd10; ahrs = 7'd5; tsec = 7'd0; tmin = 7'd10; thrs = 7'd5;
    tick = 1'b0;
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      tick = 1'b1;
      @(negedge clk);
      if (ahrs_en)         n_ahrs++;
      if (amin_en)         n_amin++;
      if (sec_en)          n_sec++;
      if (disp_alarm)      n_disp++;
      if (state_o == 3'd2) n_state++;
      next_cycle();
    end
    tick = 1'b0;
    total++;
    if (n_ahrs !== 7) begin bad++; $display("FAIL set_alarm_hrs_count got=%0d exp=7", n_ahrs); end
    total++;
    if (n_amin !== 0) begin bad++; $display("FAIL set_alarm_min_count got=%0d exp=0", n_amin); end
    total++;
    if (n_sec !== 7) begin bad++; $display("FAIL set_alarm_time_runs got=%0d exp=7", n_sec); end
    total++;
    if (n_disp !== 7) begin bad++; $display("FAIL set_alarm_disp got=%0d exp=7", n_disp); end
    total++;
    if (n_state !== 7) begin bad++; $display("FAIL set_alarm_no_trig got=%0d exp=7", n_state); end
    alarmset = 1'b0; hrsadv = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if ({state_o, buzz, disp_alarm} !== 5'b00000) begin
      bad++; $display("FAIL set_alarm_release got=%b exp=00000", {state_o, buzz, disp_alarm});
    end
    next_cycle();
    alarmon = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_alarm_ring();
    int n_ring = 0;
    amin = 7'd30; ahrs = 7'd6; alarmon = 1'b1;
    m_h = 6; m_m = 29; m_s = 59;
    tick = 1'b1;
    drive_time();
    @(negedge clk);
    total++;
    if (buzz !== 1'b0) begin bad++; $display("FAIL ring_pre_trigger got=%b exp=0", buzz); end
    next_cycle();
    adv_time();
    drive_time();             // 06:30:00 tick: the trigger
    @(negedge clk);
    total++;
    if (state_o !== 3'd0) begin bad++; $display("FAIL ring_trigger_cycle got=%0d exp=0", state_o); end
    next_cycle();
    adv_time();
    tick = 1'b0;
    @(negedge clk);
    total++;
    if ({state_o, buzz} !== 4'b0111) begin
      bad++; $display("FAIL ring_start got=%b exp=0111", {state_o, buzz});
    end
    next_cycle();
    for (int i = 0; i < 119; i++) begin
      tick = 1'b1;
      drive_time();
      @(negedge clk);
      if (buzz && state_o == 3'd3) n_ring++;
      next_cycle();
      adv_time();
    end
    total++;
    if (n_ring !== 119) begin bad++; $display("FAIL ring_hold got=%0d exp=119", n_ring); end
    drive_time();
    @(negedge clk);
    total++;
    if (buzz !== 1'b1) begin bad++; $display("FAIL ring_last_tick got=%b exp=1", buzz); end
    next_cycle();
    adv_time();
    tick = 1'b0;
    @(negedge clk);
    total++;
    if ({state_o, buzz} !== 4'b0000) begin
      bad++; $display("FAIL ring_timeout got=%b exp=0000", {state_o, buzz});
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_snooze();
    int n_snz = 0;
    amin = 7'd15; ahrs = 7'd7; alarmon = 1'b1;
    tick = 1'b1; tsec = 7'd0; tmin = 7'd15; thrs = 7'd7;
    next_cycle();
    tick = 1'b0; tsec = 7'd5;
    @(negedge clk);
    total++;
    if ({state_o, buzz} !== 4'b0111) begin
      bad++; $display("FAIL snz_ringing got=%b exp=0111", {state_o, buzz});
    end
    next_cycle();
    snooze = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if ({state_o, buzz} !== 4'b1000) begin
      bad++; $display("FAIL snz_enter got=%b exp=1000", {state_o, buzz});
    end
    next_cycle();
    for (int i = 0; i < 539; i++) begin
      tick = 1'b1;
      if (i == 3) snooze = 1'b0;
      @(negedge clk);
      if (state_o == 3'd4 && !buzz) n_snz++;
      next_cycle();
    end
    total++;
    if (n_snz !== 539) begin bad++; $display("FAIL snz_hold got=%0d exp=539", n_snz); end
    next_cycle();             // 540th tick ends the snooze
    tick = 1'b0;
    @(negedge clk);
    total++;
    if ({state_o, buzz} !== 4'b0111) begin
      bad++; $display("FAIL snz_re_ring got=%b exp=0111", {state_o, buzz});
    end
    next_cycle();
    alarmon = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if ({state_o, buzz} !== 4'b0000) begin
      bad++; $display("FAIL snz_alarm_off got=%b exp=0000", {state_o, buzz});
    end
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_both_buttons();
    timeset = 1'b1; alarmset = 1'b1; minadv = 1'b1; hrsadv = 1'b1;
    tick = 1'b1; tsec = 7'd10; tmin = 7'd3; thrs = 7'd2;
    next_cycle();
    @(negedge clk);
    total++;
    if (state_o !== 3'd0) begin bad++; $display("FAIL both_state got=%0d exp=0", state_o); end
    total++;
    if ({amin_en, ahrs_en, sec_clr, disp_alarm, tmin_en, thrs_en} !== 6'b000000) begin
      bad++;
      $display("FAIL both_no_set_en got=%b exp=000000",
               {amin_en, ahrs_en, sec_clr, disp_alarm, tmin_en, thrs_en});
    end
    total++;
    if (sec_en !== 1'b1) begin bad++; $display("FAIL both_sec_en got=%b exp=1", sec_en); end
    next_cycle();
    tsec = 7'd59;
    @(negedge clk);
    total++;
    if ({tmin_en, thrs_en} !== 2'b10) begin
      bad++; $display("FAIL both_run_carry got=%b exp=10", {tmin_en, thrs_en});
    end
    next_cycle();
    timeset = 1'b0; alarmset = 1'b0; minadv = 1'b0; hrsadv = 1'b0; tick = 1'b0;
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_ring();
    amin = 7'd0; ahrs = 7'd8; alarmon = 1'b1;
    tick = 1'b1; tsec = 7'd0; tmin = 7'd0; thrs = 7'd8;
    next_cycle();
    tick = 1'b0;
    @(negedge clk);
    total++;
    if (buzz !== 1'b1) begin bad++; $display("FAIL mid_ring_pre got=%b exp=1", buzz); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if ({state_o, buzz} !== 4'b0000) begin
      bad++; $display("FAIL mid_ring_reset got=%b exp=0000", {state_o, buzz});
    end
    next_cycle();
    rst = 1'b1;
    alarmon = 1'b0;
    next_cycle();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    next_cycle();
    test_reset();
    test_run_timing();
    test_set_time();
    test_set_alarm();
    test_alarm_ring();
    test_snooze();
    test_both_buttons();
    test_reset_mid_ring();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
